// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: CPU data port plus block-memory port of the data cache.
// slave = cache view, master = CPU/memory environment view.
interface dcache_ctrl_if;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back data cache controller, 8 blocks of 4 bytes.
// Define DCACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module dcache_ctrl #(
  parameter  int INDEX_BITS = 3,
  localparam int TAG_BITS   = 8 - INDEX_BITS - 2,
  localparam int NUM_SETS   = 2 ** INDEX_BITS
) (
  input  logic         CLK,
  input  logic         RESET,
  dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]  HIT_COUNT,
  output logic [15:0]  MISS_COUNT
`endif
);
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FETCH     = 2'd2,
    S_UPDATE    = 2'd3
  } state_t;

  state_t                         state_r, state_n;
  logic [31:0]                    data_r [NUM_SETS];
  logic [TAG_BITS-1:0]            tag_r  [NUM_SETS];
  logic [NUM_SETS-1:0]            valid_r, dirty_r;
  logic [TAG_BITS-1:0]            miss_tag_r;
  logic [INDEX_BITS-1:0]          miss_idx_r;
  logic [31:0]                    fill_r;
  logic [7:0]                     readdata_r;
  logic                           busy_seen_r;

  logic [TAG_BITS-1:0]            req_tag_s;
  logic [INDEX_BITS-1:0]          req_idx_s;
  logic [1:0]                     req_off_s;
  logic                           req_s, hit_s, done_s, wr_hit_s;
  logic [7:0]                     sel_byte_s, rdata_s;
  logic                           busy_s, mem_rd_s, mem_wr_s;
  logic [TAG_BITS+INDEX_BITS-1:0] mem_addr_s;
  logic [31:0]                    mem_wdata_s;

  assign req_tag_s  = bus.ADDRESS[7 -: TAG_BITS];
  assign req_idx_s  = bus.ADDRESS[INDEX_BITS+1:2];
  assign req_off_s  = bus.ADDRESS[1:0];
  assign req_s      = bus.READ | bus.WRITE;
  assign hit_s      = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);
  assign sel_byte_s = data_r[req_idx_s][{req_off_s, 3'b000} +: 8];
  // Memory handshake completes only on a low MEM_BUSYWAIT that follows a seen high.
  assign done_s     = busy_seen_r & ~bus.MEM_BUSYWAIT;

  assign bus.READDATA      = rdata_s;
  assign bus.BUSYWAIT      = busy_s;
  assign bus.MEM_READ      = mem_rd_s;
  assign bus.MEM_WRITE     = mem_wr_s;
  assign bus.MEM_ADDRESS   = mem_addr_s;
  assign bus.MEM_WRITEDATA = mem_wdata_s;

  // Next-state and combinational outputs; hits are served entirely in IDLE.
  always_comb begin
    state_n     = state_r;
    busy_s      = 1'b0;
    mem_rd_s    = 1'b0;
    mem_wr_s    = 1'b0;
    mem_addr_s  = 6'h00;
    mem_wdata_s = 32'h0000_0000;
    rdata_s     = readdata_r;
    wr_hit_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_s && !hit_s) begin
          busy_s = 1'b1;
          if (valid_r[req_idx_s] && dirty_r[req_idx_s]) begin
            state_n = S_WRITEBACK;
          end else begin
            state_n = S_FETCH;
          end
        end else if (bus.WRITE && hit_s) begin
          wr_hit_s = 1'b1;
        end else if (bus.READ && hit_s) begin
          rdata_s = sel_byte_s;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_WRITEBACK: begin
        busy_s      = 1'b1;
        mem_wr_s    = 1'b1;
        mem_addr_s  = {tag_r[miss_idx_r], miss_idx_r};
        mem_wdata_s = data_r[miss_idx_r];
        if (done_s) begin
          state_n = S_FETCH;
        end else begin
          state_n = S_WRITEBACK;
        end
      end
      S_FETCH: begin
        busy_s     = 1'b1;
        mem_rd_s   = 1'b1;
        mem_addr_s = {miss_tag_r, miss_idx_r};
        if (done_s) begin
          state_n = S_UPDATE;
        end else begin
          state_n = S_FETCH;
        end
      end
      S_UPDATE: begin
        busy_s  = 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Control state: FSM, valid/dirty bits, miss context and fill buffer.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= S_IDLE;
      valid_r     <= '0;
      dirty_r     <= '0;
      readdata_r  <= 8'h00;
      busy_seen_r <= 1'b0;
      miss_tag_r  <= '0;
      miss_idx_r  <= '0;
      fill_r      <= 32'h0000_0000;
    end else begin
      state_r     <= state_n;
      readdata_r  <= rdata_s;
      busy_seen_r <= (state_n == state_r) ? (busy_seen_r | bus.MEM_BUSYWAIT) : 1'b0;
      if (state_r == S_IDLE && state_n != S_IDLE) begin
        miss_tag_r <= req_tag_s;
        miss_idx_r <= req_idx_s;
      end
      if (state_r == S_FETCH && done_s) begin
        fill_r <= bus.MEM_READDATA;
      end
      if (state_r == S_UPDATE) begin
        valid_r[miss_idx_r] <= 1'b1;
        dirty_r[miss_idx_r] <= 1'b0;
      end else if (wr_hit_s) begin
        dirty_r[req_idx_s] <= 1'b1;
      end
    end
  end

  // Block and tag storage; contents are don't-care while the valid bit is clear.
  always_ff @(posedge CLK) begin
    if (!RESET && state_r == S_UPDATE) begin
      data_r[miss_idx_r] <= fill_r;
      tag_r[miss_idx_r]  <= miss_tag_r;
    end else if (!RESET && wr_hit_s) begin
      data_r[req_idx_s][{req_off_s, 3'b000} +: 8] <= bus.WRITEDATA;
    end
  end

`ifdef DCACHE_STATS_EN
  logic after_update_r;

  // Saturating counters; the replay hit right after a fill is not a hit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      HIT_COUNT      <= 16'h0000;
      MISS_COUNT     <= 16'h0000;
      after_update_r <= 1'b0;
    end else begin
      after_update_r <= (state_r == S_UPDATE);
      if (state_r == S_IDLE && state_n != S_IDLE && MISS_COUNT != 16'hFFFF) begin
        MISS_COUNT <= MISS_COUNT + 16'h0001;
      end
      if (state_r == S_IDLE && req_s && hit_s && !after_update_r && HIT_COUNT != 16'hFFFF) begin
        HIT_COUNT <= HIT_COUNT + 16'h0001;
      end
    end
  end
`endif
endmodule
